block_lock_fsm: RTL

Parametrised 64B/66B receive block-lock state machine: the configurable successor to the fixed-threshold lock block. It sits between the RX block-sync/gearbox, which presents one sync header per block, and the descrambler/decoder, which consumes `o_block_lock`. It adds:

- parametrised test-window size and invalid-header threshold;
- a post-slip settling hold-off;
- saturating slip and lock-loss statistics with a synchronous clear.

---
 rtl/block_lock_fsm_if.sv | 26 ++
 rtl/block_lock_fsm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/block_lock_fsm_if.sv
// Header/lock handshake between the RX block-sync/gearbox and the block-lock FSM.
// master: the block-sync side that presents headers and consumes slip/lock status.
// slave : the block-lock FSM itself.
interface block_lock_fsm_if #(
    parameter int HDR_WIDTH  = 2,
    parameter int STAT_WIDTH = 16
);
    logic [HDR_WIDTH-1:0]  i_hdr;
    logic                  i_hdr_valid;
    logic                  i_clear_stats;
    logic                  o_slip;
    logic                  o_block_lock;
    logic                  o_lock_lost;
    logic [STAT_WIDTH-1:0] o_slip_count;
    logic [STAT_WIDTH-1:0] o_lock_loss_count;

    modport master (
        output i_hdr, i_hdr_valid, i_clear_stats,
        input  o_slip, o_block_lock, o_lock_lost, o_slip_count, o_lock_loss_count
    );

    modport slave (
        input  i_hdr, i_hdr_valid, i_clear_stats,
        output o_slip, o_block_lock, o_lock_lost, o_slip_count, o_lock_loss_count
    );
endinterface

// File: rtl/block_lock_fsm.sv
// 64B/66B receive block-lock state machine with parametrised window size,
// invalid-header threshold, post-slip settling hold-off and saturating
// slip / lock-loss statistics. All outputs are registered.
module block_lock_fsm #(
    parameter int HDR_WIDTH      = 2,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 4,
    parameter int STAT_WIDTH     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    block_lock_fsm_if.slave  bus
);
    localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [SH_W-1:0]    sh_cnt_reg, sh_cnt_next;
    logic [INV_W-1:0]   sh_invalid_cnt_reg, sh_invalid_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               slip_reg, slip_next;
    logic               lock_reg, lock_next;
    logic               lock_lost_reg, lock_lost_next;

    // Window counters as seen by the header under test: RESET_CNT tests too,
    // but against cleared counters.
    logic [SH_W-1:0]    sh_cnt_base, sh_cnt_inc;
    logic [INV_W-1:0]   sh_invalid_base, sh_invalid_inc;
    logic [WAIT_W-1:0]  wait_cnt_inc;
    logic               hdr_ok;

    // Statistics: index 0 = slips, index 1 = lock losses.
    logic [STAT_WIDTH-1:0] stat_reg [2];
    logic                  stat_inc [2];

    generate
        if (HDR_WIDTH == 2) begin : g_hdr2
            assign hdr_ok = (bus.i_hdr == 2'b01) || (bus.i_hdr == 2'b10);
        end else begin : g_hdrn
            assign hdr_ok = ^bus.i_hdr;
        end
    endgenerate

    assign sh_cnt_base     = (state_reg == ST_RESET_CNT) ? '0 : sh_cnt_reg;
    assign sh_invalid_base = (state_reg == ST_RESET_CNT) ? '0 : sh_invalid_cnt_reg;
    assign sh_cnt_inc      = sh_cnt_base + SH_W'(1);
    assign sh_invalid_inc  = sh_invalid_base + INV_W'(1);
    assign wait_cnt_inc    = wait_cnt_reg + WAIT_W'(1);

    // Next-state and registered-output decode; slip outranks end-of-window.
    always_comb begin
        state_next          = state_reg;
        sh_cnt_next         = sh_cnt_reg;
        sh_invalid_cnt_next = sh_invalid_cnt_reg;
        wait_cnt_next       = wait_cnt_reg;
        slip_next           = 1'b0;
        lock_next           = lock_reg;
        lock_lost_next      = 1'b0;
        stat_inc[0]         = 1'b0;
        stat_inc[1]         = 1'b0;

        case (state_reg)
            ST_RESET_CNT, ST_TEST_SH: begin
                // Without a header, RESET_CNT simply clears into TEST_SH.
                sh_cnt_next         = sh_cnt_base;
                sh_invalid_cnt_next = sh_invalid_base;
                state_next          = ST_TEST_SH;
                if (bus.i_hdr_valid) begin
                    if (hdr_ok) begin
                        if (sh_cnt_inc == SH_W'(SH_CNT_MAX)) begin
                            if (sh_invalid_base == '0) begin
                                lock_next = 1'b1;
                            end
                            sh_cnt_next         = '0;
                            sh_invalid_cnt_next = '0;
                            state_next          = ST_RESET_CNT;
                        end else begin
                            sh_cnt_next = sh_cnt_inc;
                        end
                    end else if (!lock_reg || sh_invalid_inc == INV_W'(SH_INVALID_MAX)) begin
                        slip_next   = 1'b1;
                        lock_next   = 1'b0;
                        stat_inc[0] = 1'b1;
                        if (lock_reg) begin
                            lock_lost_next = 1'b1;
                            stat_inc[1]    = 1'b1;
                        end
                        sh_cnt_next         = '0;
                        sh_invalid_cnt_next = '0;
                        state_next          = (SLIP_WAIT == 0) ? ST_RESET_CNT : ST_SLIP_WAIT;
                    end else if (sh_cnt_inc == SH_W'(SH_CNT_MAX)) begin
                        sh_cnt_next         = '0;
                        sh_invalid_cnt_next = '0;
                        state_next          = ST_RESET_CNT;
                    end else begin
                        sh_cnt_next         = sh_cnt_inc;
                        sh_invalid_cnt_next = sh_invalid_inc;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (bus.i_hdr_valid) begin
                    if (wait_cnt_inc == WAIT_W'(SLIP_WAIT)) begin
                        wait_cnt_next = '0;
                        state_next    = ST_RESET_CNT;
                    end else begin
                        wait_cnt_next = wait_cnt_inc;
                    end
                end
            end
            default: begin
                state_next = ST_RESET_CNT;
            end
        endcase
    end

    // State, window counters and status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg          <= ST_RESET_CNT;
            sh_cnt_reg         <= '0;
            sh_invalid_cnt_reg <= '0;
            wait_cnt_reg       <= '0;
            slip_reg           <= 1'b0;
            lock_reg           <= 1'b0;
            lock_lost_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            sh_cnt_reg         <= sh_cnt_next;
            sh_invalid_cnt_reg <= sh_invalid_cnt_next;
            wait_cnt_reg       <= wait_cnt_next;
            slip_reg           <= slip_next;
            lock_reg           <= lock_next;
            lock_lost_reg      <= lock_lost_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            // Saturating event counter; an increment coinciding with clear leaves 1.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    stat_reg[gi] <= '0;
                end else if (bus.i_clear_stats) begin
                    stat_reg[gi] <= stat_inc[gi] ? STAT_WIDTH'(1) : '0;
                end else if (stat_inc[gi] && (stat_reg[gi] != {STAT_WIDTH{1'b1}})) begin
                    stat_reg[gi] <= stat_reg[gi] + STAT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign bus.o_slip            = slip_reg;
    assign bus.o_block_lock      = lock_reg;
    assign bus.o_lock_lost       = lock_lost_reg;
    assign bus.o_slip_count      = stat_reg[0];
    assign bus.o_lock_loss_count = stat_reg[1];

endmodule
